frame_capture_ctrl: RTL and testbench

Sequences single-frame capture from the OV7670 pixel bus into a frame-buffer write port. Sits after the synchronizer stage: all camera inputs (Vsync, Href, byte strobe, data) arrive already synchronized to Clk_i. On a capture request it waits for a clean frame start and packs byte pairs into RGB565 words with linear write addresses. It then holds a done/ack handshake with the frame consumer (display or UART reader).

---
 rtl/frame_capture_ctrl_pkg.sv | 20 ++
 rtl/frame_capture_ctrl_edge_detect.sv | 24 ++
 rtl/frame_capture_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
// Shared constants, state encoding and default QQVGA geometry
// for the OV7670 single-frame capture controller.
package frame_capture_ctrl_pkg;

    localparam logic low_p  = 1'b0;
    localparam logic high_p = 1'b1;

    localparam int H_PIXELS_DEF = 160;
    localparam int V_LINES_DEF  = 120;
    localparam int ADDR_W_DEF   = 15;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_VS_HIGH = 3'd1,
        WAIT_VS_LOW  = 3'd2,
        CAPTURE      = 3'd3,
        DONE         = 3'd4
    } state_e;

endpackage

// File: rtl/frame_capture_ctrl_edge_detect.sv
// Rise/fall pulse generator against a registered copy of the input.
// Pulses are valid in the first cycle the new level is seen.
module frame_capture_ctrl_edge_detect (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic Sig_i,
    output logic Rise_o,
    output logic Fall_o
);

    logic sig_q;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= Sig_i;
        end
    end

    assign Rise_o = Sig_i & ~sig_q;
    assign Fall_o = ~Sig_i & sig_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame OV7670 capture: waits for a clean frame start, packs
// byte pairs into RGB565 words and hands the frame over via done/ack.
module frame_capture_ctrl
    import frame_capture_ctrl_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              Capture_Req_i,
    input  logic              Frame_Ack_i,
    input  logic              Vsync_i,
    input  logic              Href_i,
    input  logic              Byte_Strobe_i,
    input  logic [7:0]        Data_i,
    output logic              Wr_En_o,
    output logic [ADDR_W-1:0] Wr_Addr_o,
    output logic [15:0]       Wr_Data_o,
    output logic              Busy_o,
    output logic              Frame_Done_o,
    output logic              Error_o
);

    localparam int N_PIX  = H_PIXELS * V_LINES;
    localparam int CNT_W  = $clog2(N_PIX + 1);
    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);

    localparam logic [CNT_W-1:0]  N_CNT = CNT_W'(N_PIX);
    localparam logic [COL_W-1:0]  H_MAX = COL_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);

    state_e state_q, state_d;

    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic vs_rise, vs_fall;
    logic href_rise, href_fall;
    logic unused_edges;

    logic in_cap, start, byte_ok, pix_ok, fits, do_wr;

    frame_capture_ctrl_edge_detect u_vs_edge (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Sig_i   (Vsync_i),
        .Rise_o  (vs_rise),
        .Fall_o  (vs_fall)
    );

    frame_capture_ctrl_edge_detect u_href_edge (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Sig_i   (Href_i),
        .Rise_o  (href_rise),
        .Fall_o  (href_fall)
    );

    assign unused_edges = vs_fall | href_rise;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Capture_Req_i == high_p) state_d = WAIT_VS_HIGH;
            end
            WAIT_VS_HIGH: begin
                if (Vsync_i == high_p) state_d = WAIT_VS_LOW;
            end
            WAIT_VS_LOW: begin
                if (Vsync_i == low_p) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (vs_rise) state_d = DONE;
            end
            DONE: begin
                if (Frame_Ack_i == high_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy_o       = low_p;
        Frame_Done_o = low_p;
        unique case (state_q)
            IDLE: ;
            WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE: begin
                Busy_o = high_p;
            end
            DONE: begin
                Busy_o       = high_p;
                Frame_Done_o = high_p;
            end
            default: ;
        endcase
    end

    assign in_cap  = (state_q == CAPTURE);
    assign start   = (state_q == WAIT_VS_LOW) && (Vsync_i == low_p);
    assign byte_ok = in_cap & Href_i & Byte_Strobe_i;
    assign pix_ok  = byte_ok & phase_q;
    assign fits    = (col_q < H_MAX) && (line_q < V_MAX);
    assign do_wr   = pix_ok & fits;

    // Href fall and a packed byte are exclusive: a byte needs Href high.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        col_d     = col_q;
        line_d    = line_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        err_d     = err_q;
        wr_en_d   = do_wr;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (start) begin
            pix_cnt_d = '0;
            col_d     = '0;
            line_d    = '0;
            phase_d   = 1'b0;
            err_d     = 1'b0;
        end else if (in_cap) begin
            if (href_fall) begin
                phase_d = 1'b0;
                if (phase_q) err_d = 1'b1;
                if (col_q != '0) begin
                    col_d  = '0;
                    line_d = (line_q == V_MAX) ? line_q : line_q + 1'b1;
                end
            end else if (byte_ok && !phase_q) begin
                hi_d    = Data_i;
                phase_d = 1'b1;
            end else if (pix_ok) begin
                phase_d = 1'b0;
                col_d   = (col_q == H_MAX) ? col_q : col_q + 1'b1;
                if (do_wr) begin
                    wr_addr_d = ADDR_W'(pix_cnt_q);
                    wr_data_d = {hi_q, Data_i};
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            // The same-cycle last pixel is counted before the short-frame test.
            if (vs_rise && (pix_cnt_d != N_CNT)) err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            pix_cnt_q <= '0;
            col_q     <= '0;
            line_q    <= '0;
            phase_q   <= 1'b0;
            hi_q      <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            col_q     <= col_d;
            line_q    <= line_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign Wr_En_o   = wr_en_q;
    assign Wr_Addr_o = wr_addr_q;
    assign Wr_Data_o = wr_data_q;
    assign Error_o   = err_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl at a 4x2 geometry.
// Expected writes are queued as bytes are driven and popped on Wr_En_o.
module tb_frame_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;
    localparam int N  = H * V;

    logic          clk = 1'b0;
    logic          Reset_i;
    logic          Capture_Req_i;
    logic          Frame_Ack_i;
    logic          Vsync_i;
    logic          Href_i;
    logic          Byte_Strobe_i;
    logic [7:0]    Data_i;
    logic          Wr_En_o;
    logic [AW-1:0] Wr_Addr_o;
    logic [15:0]   Wr_Data_o;
    logic          Busy_o;
    logic          Frame_Done_o;
    logic          Error_o;

    int checks = 0;
    int errors = 0;

    logic [AW+15:0] sb[$];
    logic [AW+15:0] mon_exp;

    int exp_addr;
    int exp_col;
    int exp_line;
    bit exp_err;
    bit model_on;

    always #5 clk = ~clk;

    frame_capture_ctrl #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (AW)
    ) dut (
        .Clk_i         (clk),
        .Reset_i       (Reset_i),
        .Capture_Req_i (Capture_Req_i),
        .Frame_Ack_i   (Frame_Ack_i),
        .Vsync_i       (Vsync_i),
        .Href_i        (Href_i),
        .Byte_Strobe_i (Byte_Strobe_i),
        .Data_i        (Data_i),
        .Wr_En_o       (Wr_En_o),
        .Wr_Addr_o     (Wr_Addr_o),
        .Wr_Data_o     (Wr_Data_o),
        .Busy_o        (Busy_o),
        .Frame_Done_o  (Frame_Done_o),
        .Error_o       (Error_o)
    );

    always @(negedge clk) begin
        if (Reset_i && Wr_En_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h",
                         Wr_Addr_o, Wr_Data_o);
            end else begin
                mon_exp = sb.pop_front();
                if ({Wr_Addr_o, Wr_Data_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             Wr_Addr_o, Wr_Data_o,
                             mon_exp[AW+15:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_addr = 0;
        exp_col  = 0;
        exp_line = 0;
        exp_err  = 1'b0;
        model_on = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Byte_Strobe_i = 1'b1;
        Data_i        = b;
        tick();
        Byte_Strobe_i = 1'b0;
        tick();
    endtask

    task automatic send_line(input int nbytes, input int base,
                             input bit keep_href);
        logic [7:0] hi;
        logic [7:0] lo;
        Href_i = 1'b1;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            if (model_on && (i % 2 == 1)) begin
                hi = 8'(base + i - 1);
                lo = 8'(base + i);
                if (exp_col < H && exp_line < V) begin
                    sb.push_back({AW'(exp_addr), hi, lo});
                    exp_addr++;
                end else begin
                    exp_err = 1'b1;
                end
                exp_col++;
            end
            send_byte(8'(base + i));
        end
        if (!keep_href) begin
            Href_i = 1'b0;
            tick();
            if (model_on) begin
                if (nbytes % 2 == 1) exp_err = 1'b1;
                if (exp_col > 0) begin
                    exp_col = 0;
                    exp_line++;
                end
            end
        end
    endtask

    task automatic request();
        Capture_Req_i = 1'b1;
        tick();
        Capture_Req_i = 1'b0;
    endtask

    task automatic start_frame();
        Vsync_i = 1'b1;
        tick();
        tick();
        Vsync_i = 1'b0;
        tick();
        tick();
        model_reset();
    endtask

    task automatic end_frame(input string name);
        int n;
        Vsync_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Frame_Done_o && n < 8);
        tick();
        model_on = 1'b0;
        if (exp_addr != N) exp_err = 1'b1;
        checks++;
        if (Frame_Done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got=%b want=1", name, Frame_Done_o);
        end
        checks++;
        if (Error_o !== exp_err) begin
            errors++;
            $display("FAIL %s_error got=%b want=%b", name, Error_o, exp_err);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes got=%0d want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic ack(input string name);
        Frame_Ack_i = 1'b1;
        tick();
        Frame_Ack_i = 1'b0;
        Vsync_i     = 1'b0;
        checks++;
        if ({Frame_Done_o, Busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL %s_ack done/busy got=%b%b want=00",
                     name, Frame_Done_o, Busy_o);
        end
        tick();
    endtask

    task automatic test_reset();
        Reset_i       = 1'b0;
        Capture_Req_i = 1'b0;
        Frame_Ack_i   = 1'b0;
        Vsync_i       = 1'b0;
        Href_i        = 1'b0;
        Byte_Strobe_i = 1'b0;
        Data_i        = '0;
        model_on      = 1'b0;
        tick();
        tick();
        Reset_i = 1'b1;
        tick();
        checks++;
        if ({Wr_En_o, Wr_Addr_o, Wr_Data_o, Busy_o, Frame_Done_o, Error_o}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%h busy=%b done=%b err=%b want all 0",
                     Wr_En_o, Wr_Addr_o, Wr_Data_o, Busy_o, Frame_Done_o, Error_o);
        end
    endtask

    task automatic test_basic_frame();
        request();
        start_frame();
        send_line(8, 8'h00, 1'b0);
        send_line(8, 8'h08, 1'b0);
        end_frame("basic");
        ack("basic");
    endtask

    task automatic test_mid_frame_request();
        request();
        send_line(8, 8'h40, 1'b0);
        checks++;
        if (Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midreq_busy got=%b want=1", Busy_o);
        end
        start_frame();
        send_line(8, 8'h50, 1'b0);
        send_line(8, 8'h60, 1'b0);
        end_frame("midreq");
        ack("midreq");
    endtask

    task automatic test_long_line();
        request();
        start_frame();
        send_line(10, 8'h20, 1'b0);
        send_line(8, 8'h30, 1'b0);
        end_frame("longline");
        ack("longline");
    endtask

    task automatic test_short_frame();
        request();
        start_frame();
        send_line(8, 8'h70, 1'b0);
        end_frame("short");
        ack("short");
    endtask

    task automatic test_reset_mid_capture();
        request();
        start_frame();
        send_line(6, 8'h80, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rstmid_pre_writes pending got=%0d want=0", sb.size());
            sb.delete();
        end
        Reset_i = 1'b0;
        #1;
        checks++;
        if ({Wr_En_o, Wr_Addr_o, Wr_Data_o, Busy_o, Frame_Done_o, Error_o}
            !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got en=%b addr=%0d data=%h busy=%b done=%b err=%b want all 0",
                     Wr_En_o, Wr_Addr_o, Wr_Data_o, Busy_o, Frame_Done_o, Error_o);
        end
        model_on = 1'b0;
        Href_i   = 1'b0;
        tick();
        tick();
        Reset_i = 1'b1;
        tick();
        request();
        start_frame();
        send_line(8, 8'h90, 1'b0);
        send_line(8, 8'hA0, 1'b0);
        end_frame("rstmid");
        ack("rstmid");
    endtask

    task automatic test_done_hold();
        request();
        start_frame();
        send_line(8, 8'hB0, 1'b0);
        send_line(8, 8'hC0, 1'b0);
        end_frame("hold");
        Href_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Capture_Req_i = (i % 5 == 0);
            Byte_Strobe_i = 1'b1;
            Data_i        = 8'(i);
            tick();
        end
        Capture_Req_i = 1'b0;
        Byte_Strobe_i = 1'b0;
        Href_i        = 1'b0;
        tick();
        checks++;
        if ({Frame_Done_o, Busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL hold_state done/busy got=%b%b want=11",
                     Frame_Done_o, Busy_o);
        end
        ack("hold");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_mid_frame_request();
        test_long_line();
        test_short_frame();
        test_reset_mid_capture();
        test_done_hold();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
